// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting N_REQ managers access to a single shared slave.
// One transaction per grant, with a cycle timeout and early release on request withdrawal.
module bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          m_valid,
    input  logic [N_REQ-1:0]          m_wr_en,
    input  logic [N_REQ*ADDR_W-1:0]   m_addr,
    input  logic [N_REQ*DATA_W-1:0]   m_wdata,
    output logic [N_REQ-1:0]          m_ready,
    output logic [N_REQ-1:0]          m_err,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      s_valid,
    output logic                      s_wr_en,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic                      s_ready,
    input  logic [DATA_W-1:0]         s_rdata,
    output logic [N_REQ-1:0]          grant,
    output logic                      dbg_state,
    output logic [$clog2(N_REQ)-1:0]  dbg_ptr
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] ptr_next;
    logic             busy;
    logic             g_valid;
    logic             done;
    logic             tmo;
    logic             drop;

    // Scan upward from ptr with wrap; the first requester found wins.
    always_comb begin
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && m_valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) gidx = PTR_W'(i);
        end
    end

    assign busy     = (state == ST_BUSY);
    assign g_valid  = |(m_valid & grant_q);
    assign drop     = busy && !g_valid;
    assign done     = busy && g_valid && s_ready;
    // s_ready in the last allowed cycle wins over the timeout.
    assign tmo      = busy && g_valid && !s_ready && (cnt == CNT_W'(TIMEOUT - 1));
    assign ptr_next = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    assign s_valid   = busy && g_valid;
    assign s_wr_en   = busy ? m_wr_en[gidx] : 1'b0;
    assign s_addr    = busy ? m_addr[gidx*ADDR_W +: ADDR_W] : '0;
    assign s_wdata   = busy ? m_wdata[gidx*DATA_W +: DATA_W] : '0;
    assign m_ready   = done ? grant_q : '0;
    assign m_err     = tmo ? grant_q : '0;
    assign m_rdata   = s_rdata;
    assign grant     = grant_q;
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (|m_valid) begin
                        grant_q <= pick;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done || tmo || drop) begin
                        grant_q <= '0;
                        ptr     <= ptr_next;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter; completion/timeout strobes are
// matched against an expected queue filled when the slave response is driven.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int W  = 1 + 3 + DW;

    logic          clk;
    logic          rst;
    logic [N-1:0]  m_valid;
    logic [N-1:0]  m_wr_en;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]  m_ready;
    logic [N-1:0]  m_err;
    logic [DW-1:0] m_rdata;
    logic          s_valid;
    logic          s_wr_en;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_ready;
    logic [DW-1:0] s_rdata;
    logic [N-1:0]  grant;
    logic          dbg_state;
    logic [1:0]    dbg_ptr;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mgr(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_wr_en[i]         = wr;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    function automatic logic [2:0] oh_idx(input logic [N-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic push_exp(input logic err, input int idx, input logic [DW-1:0] d);
        exp_q.push_back({err, 3'(idx), d});
    endtask

    // scoreboard: every strobe must match the oldest expected response
    always @(negedge clk) begin
        if (|m_ready || |m_err) begin
            check_eq("strobe_excl",
                     64'($onehot0(m_ready) && $onehot0(m_err) && !(|m_ready && |m_err)), 64'd1);
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", 64'({m_ready, m_err}), 64'd0);
            end else begin
                check_eq("sb_strobe", 64'({|m_err, oh_idx(m_ready | m_err), m_rdata}),
                         64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int i;
        int d;
        logic wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;

        rst = 1'b1; m_valid = '0; m_wr_en = '0; m_addr = '0; m_wdata = '0;
        s_ready = 1'b0; s_rdata = '0;
        tick();
        m_valid = 4'b1111;
        m_wr_en = 4'b1111;
        m_addr  = '1;
        m_wdata = '1;
        s_ready = 1'b1;
        tick();
        @(negedge clk);
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_s_valid", 64'(s_valid), 64'd0);
        check_eq("rst_s_wr_en", 64'(s_wr_en), 64'd0);
        check_eq("rst_s_addr", 64'(s_addr), 64'd0);
        check_eq("rst_s_wdata", 64'(s_wdata), 64'd0);
        check_eq("rst_m_ready", 64'(m_ready), 64'd0);
        check_eq("rst_m_err", 64'(m_err), 64'd0);
        check_eq("rst_ptr", 64'(dbg_ptr), 64'd0);
        check_eq("rst_state", 64'(dbg_state), 64'd0);
        tick();
        rst = 1'b0; m_valid = '0; m_wr_en = '0; m_addr = '0; m_wdata = '0; s_ready = 1'b0;

        // single write from manager 1, slave ready in the 2nd busy cycle
        tick();
        m_valid = 4'b0010;
        set_mgr(1, 1'b1, 8'h10, 32'hABCD1234);
        @(negedge clk);
        check_eq("t1_req_idle", 64'(s_valid), 64'd0);
        tick();
        @(negedge clk);
        check_eq("t1_latency", 64'(s_valid), 64'd1);
        check_eq("t1_grant", 64'(grant), 64'b0010);
        check_eq("t1_s_addr", 64'(s_addr), 64'h10);
        check_eq("t1_s_wdata", 64'(s_wdata), 64'hABCD1234);
        check_eq("t1_s_wr_en", 64'(s_wr_en), 64'd1);
        check_eq("t1_no_ready_yet", 64'(m_ready), 64'd0);
        tick();
        s_ready = 1'b1;
        push_exp(1'b0, 1, s_rdata);
        @(negedge clk);
        check_eq("t1_m_ready", 64'(m_ready), 64'b0010);
        tick();
        s_ready = 1'b0; m_valid = '0;
        @(negedge clk);
        check_eq("t1_ptr", 64'(dbg_ptr), 64'd2);
        check_eq("t1_idle", 64'(s_valid), 64'd0);
        check_eq("t1_ready_once", 64'(m_ready), 64'd0);

        // all four requesting, slave always ready: rotation 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 4'b1111; m_wr_en = '0; s_ready = 1'b1; s_rdata = 32'h0BADF00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("rr_idle_gap", 64'(grant), 64'd0);
            tick();
            push_exp(1'b0, k % N, s_rdata);
            @(negedge clk);
            check_eq("rr_grant", 64'(grant), 64'(4'b0001 << (k % N)));
            tick();
        end
        m_valid = '0; s_ready = 1'b0;

        // read from manager 2
        m_valid = 4'b0100;
        set_mgr(2, 1'b0, 8'h10, 32'h0);
        s_rdata = 32'h55AA00FF;
        @(negedge clk);
        tick();
        s_ready = 1'b1;
        push_exp(1'b0, 2, s_rdata);
        @(negedge clk);
        check_eq("t3_m_ready", 64'(m_ready), 64'b0100);
        check_eq("t3_m_rdata", 64'(m_rdata), 64'h55AA00FF);
        check_eq("t3_s_wr_en", 64'(s_wr_en), 64'd0);
        check_eq("t3_s_addr", 64'(s_addr), 64'h10);
        tick();
        m_valid = '0; s_ready = 1'b0;

        // slave never ready: timeout in the 16th busy cycle (ptr=3 so manager 0 wins)
        m_valid = 4'b0011;
        @(negedge clk);
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) push_exp(1'b1, 0, s_rdata);
            @(negedge clk);
            check_eq("t4_grant", 64'(grant), 64'b0001);
            check_eq("t4_m_err", 64'(m_err), (c == 16) ? 64'b0001 : 64'd0);
            tick();
        end
        @(negedge clk);
        check_eq("t4_gap", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        check_eq("t4_next", 64'(grant), 64'b0010);
        tick();
        m_valid = '0;
        @(negedge clk);
        check_eq("t4_drop_s_valid", 64'(s_valid), 64'd0);
        tick();

        // reset in the 3rd busy cycle
        m_valid = 4'b0100;
        @(negedge clk);
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_busy3", 64'(grant), 64'b0100);
        tick();
        rst = 1'b0; m_valid = '0;
        @(negedge clk);
        check_eq("t5_grant", 64'(grant), 64'd0);
        check_eq("t5_s_valid", 64'(s_valid), 64'd0);
        check_eq("t5_ptr", 64'(dbg_ptr), 64'd0);
        check_eq("t5_strobes", 64'({m_ready, m_err}), 64'd0);
        tick();

        // manager 0 withdraws mid-transaction while manager 3 waits
        m_valid = 4'b1001;
        @(negedge clk);
        tick();
        @(negedge clk);
        check_eq("t6_grant0", 64'(grant), 64'b0001);
        tick();
        m_valid = 4'b1000;
        @(negedge clk);
        check_eq("t6_drop_s_valid", 64'(s_valid), 64'd0);
        check_eq("t6_drop_strobes", 64'({m_ready, m_err}), 64'd0);
        tick();
        @(negedge clk);
        check_eq("t6_idle", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        check_eq("t6_grant3", 64'(grant), 64'b1000);
        tick();
        s_ready = 1'b1;
        push_exp(1'b0, 3, s_rdata);
        @(negedge clk);
        tick();
        m_valid = '0; s_ready = 1'b0;

        // randomized single-requester transactions with variable slave delay
        for (int r = 0; r < 10; r++) begin
            i  = $urandom_range(0, N - 1);
            d  = $urandom_range(1, 4);
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            wd = $urandom;
            m_valid = '0;
            m_valid[i] = 1'b1;
            set_mgr(i, wr, a, wd);
            @(negedge clk);
            check_eq("rnd_idle", 64'(s_valid), 64'd0);
            tick();
            for (int c = 1; c <= d; c++) begin
                if (c == d) begin
                    s_rdata = $urandom;
                    s_ready = 1'b1;
                    push_exp(1'b0, i, s_rdata);
                end
                @(negedge clk);
                check_eq("rnd_grant", 64'(grant), 64'(4'b0001 << i));
                check_eq("rnd_s_addr", 64'(s_addr), 64'(a));
                check_eq("rnd_s_wdata", 64'(s_wdata), 64'(wd));
                check_eq("rnd_s_wr_en", 64'(s_wr_en), 64'(wr));
                tick();
            end
            m_valid = '0; s_ready = 1'b0;
        end

        tick();
        @(negedge clk);
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
